// File: rtl/z80_uart_io_ctrl_pkg.sv
// Shared types and constants for the Z80 UART I/O controller: FSM states, port offsets,
// status-register bit positions and the value returned when a read has no real data.
package z80_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STATUS,
        ST_RX_REQ,
        ST_RX_ACK,
        ST_TX_REQ,
        ST_TX_ACK,
        ST_HOLD
    } state_t;

    localparam logic [7:0] PORT_DATA_OFS   = 8'd0;
    localparam logic [7:0] PORT_STATUS_OFS = 8'd1;

    localparam int ST_BIT_RX_AVAIL    = 0;
    localparam int ST_BIT_TX_FULL     = 1;
    localparam int ST_BIT_RX_UNDERRUN = 2;
    localparam int ST_BIT_TX_OVERRUN  = 3;
    localparam int ST_BIT_TIMEOUT     = 4;
    localparam int ST_BIT_IRQ_EN      = 7;

    localparam logic [7:0] BUS_FLOAT = 8'hFF;

    typedef struct packed {
        logic timeout;
        logic tx_overrun;
        logic rx_underrun;
    } flags_t;

    function automatic logic [7:0] pack_status(input logic rx_avail, input logic tx_full,
                                               input flags_t flags, input logic irq_en);
        logic [7:0] s;
        s                     = 8'h00;
        s[ST_BIT_RX_AVAIL]    = rx_avail;
        s[ST_BIT_TX_FULL]     = tx_full;
        s[ST_BIT_RX_UNDERRUN] = flags.rx_underrun;
        s[ST_BIT_TX_OVERRUN]  = flags.tx_overrun;
        s[ST_BIT_TIMEOUT]     = flags.timeout;
        s[ST_BIT_IRQ_EN]      = irq_en;
        return s;
    endfunction

endpackage

// File: rtl/z80_uart_io_ctrl_if.sv
// Wishbone pop/push bundle between the I/O controller (master) and the UART RX/TX slaves.
interface z80_uart_io_ctrl_if;
    logic       o_rx_wb_cyc;
    logic       o_rx_wb_stb;
    logic [7:0] i_rx_wb_data;
    logic       i_rx_wb_ack;
    logic       i_rx_wb_stall;
    logic       i_rx_empty;

    logic       o_tx_wb_cyc;
    logic       o_tx_wb_stb;
    logic [7:0] o_tx_wb_data;
    logic       i_tx_wb_ack;
    logic       i_tx_wb_stall;
    logic       i_tx_full;

    modport master (
        output o_rx_wb_cyc, o_rx_wb_stb,
        input  i_rx_wb_data, i_rx_wb_ack, i_rx_wb_stall, i_rx_empty,
        output o_tx_wb_cyc, o_tx_wb_stb, o_tx_wb_data,
        input  i_tx_wb_ack, i_tx_wb_stall, i_tx_full
    );

    modport slave (
        input  o_rx_wb_cyc, o_rx_wb_stb,
        output i_rx_wb_data, i_rx_wb_ack, i_rx_wb_stall, i_rx_empty,
        input  o_tx_wb_cyc, o_tx_wb_stb, o_tx_wb_data,
        output i_tx_wb_ack, i_tx_wb_stall, i_tx_full
    );
endinterface

// File: rtl/z80_uart_io_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous control line; resets to RESET_VAL so an
// idle active-low Z80 strobe never looks asserted coming out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;
endmodule

// File: rtl/z80_uart_io_ctrl.sv
// Z80 IN/OUT decoder that turns each DATA/STATUS port access into one wishbone pop or push,
// stretching the Z80 cycle with WAIT_n. Optional RX interrupt enabled by defining UART_IRQ_EN.
module z80_uart_io_ctrl
    import z80_io_pkg::*;
#(
    parameter logic [7:0]               BASE_PORT      = 8'h80,
    parameter int                       TIMEOUT_WIDTH  = 16,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_z80_iorq_n,
    input  logic       i_z80_rd_n,
    input  logic       i_z80_wr_n,
    input  logic       i_z80_m1_n,
    input  logic [7:0] i_z80_addr,
    input  logic [7:0] i_z80_data,
    output logic [7:0] o_z80_data,
    output logic       o_z80_data_oe,
    output logic       o_z80_wait_n,
    output logic       o_z80_int_n,
    z80_uart_io_ctrl_if.master wb
);

    logic [3:0] raw_bus;
    logic [3:0] sync_bus;
    logic       iorq_s, rd_s, wr_s, m1_s;

    assign raw_bus = {i_z80_m1_n, i_z80_wr_n, i_z80_rd_n, i_z80_iorq_n};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        sync_2ff #(.RESET_VAL(1'b1)) u_sync (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_d       (raw_bus[gi]),
            .o_q       (sync_bus[gi])
        );
    end

    assign iorq_s = sync_bus[0];
    assign rd_s   = sync_bus[1];
    assign wr_s   = sync_bus[2];
    assign m1_s   = sync_bus[3];

    state_t                   state_q, state_d;
    logic                     req_prev_q, req_prev_d;
    logic                     rd_op_q, rd_op_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    flags_t                   flags_q, flags_d;
    logic [7:0]               z80_data_q, z80_data_d;
    logic                     data_oe_q, data_oe_d;
    logic                     wait_n_q, wait_n_d;
    logic                     rx_cyc_q, rx_cyc_d, rx_stb_q, rx_stb_d;
    logic                     tx_cyc_q, tx_cyc_d, tx_stb_q, tx_stb_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     req_now, hit_data, hit_status, detect, expire, abort;
    logic                     irq_bit;

`ifdef UART_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic int_n_q, int_n_d;
    assign irq_bit     = irq_en_q;
    assign o_z80_int_n = int_n_q;
`else
    assign irq_bit     = 1'b0;
    assign o_z80_int_n = 1'b1;
`endif

    // INT-acknowledge cycles (IORQ with M1 low) must never look like a port access.
    assign req_now    = !iorq_s && m1_s && (!rd_s || !wr_s);
    assign hit_data   = (i_z80_addr == BASE_PORT + PORT_DATA_OFS);
    assign hit_status = (i_z80_addr == BASE_PORT + PORT_STATUS_OFS);
    assign detect     = (state_q == ST_IDLE) && req_now && !req_prev_q && (hit_data || hit_status);
    assign cnt_inc    = cnt_q + 1'b1;
    assign expire     = (cnt_inc == TIMEOUT_CYCLES);

    always_comb begin
        state_d    = state_q;
        req_prev_d = req_now;
        rd_op_d    = rd_op_q;
        cnt_d      = cnt_q;
        flags_d    = flags_q;
        z80_data_d = z80_data_q;
        rx_cyc_d   = rx_cyc_q;
        rx_stb_d   = rx_stb_q;
        tx_cyc_d   = tx_cyc_q;
        tx_stb_d   = tx_stb_q;
        tx_data_d  = tx_data_q;
        abort      = 1'b0;
`ifdef UART_IRQ_EN
        irq_en_d   = irq_en_q;
        int_n_d    = !(!wb.i_rx_empty && irq_en_q);
`endif
        case (state_q)
            ST_IDLE: begin
                if (detect) begin
                    rd_op_d = !rd_s;
                    cnt_d   = '0;
                    if (hit_status) begin
                        if (!rd_s) begin
                            state_d = ST_STATUS;
                        end else begin
                            flags_d = '0;
`ifdef UART_IRQ_EN
                            irq_en_d = i_z80_data[ST_BIT_IRQ_EN];
`endif
                            state_d = ST_HOLD;
                        end
                    end else if (!rd_s) begin
                        if (!wb.i_rx_empty) begin
                            rx_cyc_d = 1'b1;
                            rx_stb_d = 1'b1;
                            state_d  = ST_RX_REQ;
                        end else begin
                            z80_data_d          = BUS_FLOAT;
                            flags_d.rx_underrun = 1'b1;
                            state_d             = ST_HOLD;
                        end
                    end else begin
                        if (!wb.i_tx_full) begin
                            tx_cyc_d  = 1'b1;
                            tx_stb_d  = 1'b1;
                            tx_data_d = i_z80_data;
                            state_d   = ST_TX_REQ;
                        end else begin
                            flags_d.tx_overrun = 1'b1;
                            state_d            = ST_HOLD;
                        end
                    end
                end
            end
            ST_STATUS: begin
                z80_data_d = pack_status(!wb.i_rx_empty, wb.i_tx_full, flags_q, irq_bit);
                state_d    = ST_HOLD;
            end
            ST_RX_REQ: begin
                cnt_d = cnt_inc;
                if (expire) begin
                    abort = 1'b1;
                end else if (!wb.i_rx_wb_stall) begin
                    rx_stb_d = 1'b0;
                    state_d  = ST_RX_ACK;
                end
            end
            ST_RX_ACK: begin
                cnt_d = cnt_inc;
                // A late ack on the expiry cycle still completes the pop so no byte is lost.
                if (wb.i_rx_wb_ack) begin
                    z80_data_d = wb.i_rx_wb_data;
                    rx_cyc_d   = 1'b0;
                    state_d    = ST_HOLD;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            ST_TX_REQ: begin
                cnt_d = cnt_inc;
                if (expire) begin
                    abort = 1'b1;
                end else if (!wb.i_tx_wb_stall) begin
                    tx_stb_d = 1'b0;
                    state_d  = ST_TX_ACK;
                end
            end
            ST_TX_ACK: begin
                cnt_d = cnt_inc;
                if (wb.i_tx_wb_ack) begin
                    tx_cyc_d = 1'b0;
                    state_d  = ST_HOLD;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            ST_HOLD: begin
                if (iorq_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            rx_cyc_d        = 1'b0;
            rx_stb_d        = 1'b0;
            tx_cyc_d        = 1'b0;
            tx_stb_d        = 1'b0;
            z80_data_d      = BUS_FLOAT;
            flags_d.timeout = 1'b1;
            state_d         = ST_HOLD;
        end

        wait_n_d  = (state_d == ST_IDLE) || (state_d == ST_HOLD);
        data_oe_d = (state_d == ST_HOLD) && rd_op_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            req_prev_q <= 1'b0;
            rd_op_q    <= 1'b0;
            cnt_q      <= '0;
            flags_q    <= '0;
            z80_data_q <= 8'h00;
            data_oe_q  <= 1'b0;
            wait_n_q   <= 1'b1;
            rx_cyc_q   <= 1'b0;
            rx_stb_q   <= 1'b0;
            tx_cyc_q   <= 1'b0;
            tx_stb_q   <= 1'b0;
            tx_data_q  <= 8'h00;
`ifdef UART_IRQ_EN
            irq_en_q   <= 1'b0;
            int_n_q    <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            req_prev_q <= req_prev_d;
            rd_op_q    <= rd_op_d;
            cnt_q      <= cnt_d;
            flags_q    <= flags_d;
            z80_data_q <= z80_data_d;
            data_oe_q  <= data_oe_d;
            wait_n_q   <= wait_n_d;
            rx_cyc_q   <= rx_cyc_d;
            rx_stb_q   <= rx_stb_d;
            tx_cyc_q   <= tx_cyc_d;
            tx_stb_q   <= tx_stb_d;
            tx_data_q  <= tx_data_d;
`ifdef UART_IRQ_EN
            irq_en_q   <= irq_en_d;
            int_n_q    <= int_n_d;
`endif
        end
    end

    assign o_z80_data      = z80_data_q;
    assign o_z80_data_oe   = data_oe_q;
    assign o_z80_wait_n    = wait_n_q;
    assign wb.o_rx_wb_cyc  = rx_cyc_q;
    assign wb.o_rx_wb_stb  = rx_stb_q;
    assign wb.o_tx_wb_cyc  = tx_cyc_q;
    assign wb.o_tx_wb_stb  = tx_stb_q;
    assign wb.o_tx_wb_data = tx_data_q;

endmodule
